order_fetch: RTL and testbench

ORDER_FETCH -- requirements
Module: order_fetch

---
 rtl/order_fetch.sv | 194 +++++++++++++++++++
 tb/tb_order_fetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_fetch.sv
// ---------------------------------------------------------------------------
// order_fetch -- instruction fetch stage
//
// Walks a 32-bit program counter through instruction memory, presenting one
// instruction per cycle to the decode stage. A single-entry hold buffer keeps
// a word that returns while decode is stalled. A redirect (jump) flushes
// everything. A pending soft interrupt is injected into the decode slot ahead
// of the next instruction.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   isStop             : downstream stall, output registers hold while 1
//   jump, jumpAddress  : one-cycle redirect pulse and target (bits[1:0] ignored)
//   imem_req/addr      : memory read request and word-aligned address
//   imem_ack/data      : one-cycle read response
//   int_req, int_num   : level soft-interrupt request and vector
//   int_accept         : one-cycle pulse when the interrupt is injected
//   order, thisOrderAddress, this_isRunning, interrupt, interrupt_num :
//                        registered decode-slot outputs
// ---------------------------------------------------------------------------
module order_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        isStop,
    input  logic        jump,
    input  logic [31:0] jumpAddress,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        int_req,
    input  logic [7:0]  int_num,
    output logic        int_accept,
    output logic [31:0] order,
    output logic [31:0] thisOrderAddress,
    output logic        this_isRunning,
    output logic        interrupt,
    output logic [7:0]  interrupt_num
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [31:0] order_q, order_d;
    logic [31:0] addr_q, addr_d;
    logic        running_q, running_d;
    logic        intr_q, intr_d;
    logic [7:0]  intr_num_q, intr_num_d;
    logic        int_accept_q, int_accept_d;

    logic [31:0] jump_pc;
    logic        int_take;

    assign jump_pc = {jumpAddress[31:2], 2'b00};

    // An interrupt is injected only on a slot load without a redirect, and
    // never in the cycle right after a previous injection so a held request
    // cannot produce back-to-back pulses.
    assign int_take = !rst && !jump && !isStop && int_req && !int_accept_q;

    // The request is dropped combinationally during a redirect so that the
    // stale address is never acknowledged; the new target goes out next cycle.
    assign imem_req   = (state_q == S_FETCH) && !jump;
    assign imem_addr  = pc_q;
    assign int_accept = int_take;

    assign order            = order_q;
    assign thisOrderAddress = addr_q;
    assign this_isRunning   = running_q;
    assign interrupt        = intr_q;
    assign interrupt_num    = intr_num_q;

    always_comb begin
        // NOTE: every signal assigned here starts from its held value so no
        // path through the branches below can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        order_d      = order_q;
        addr_d       = addr_q;
        running_d    = running_q;
        intr_d       = intr_q;
        intr_num_d   = intr_num_q;
        int_accept_d = int_take;

        if (jump) begin
            // Flush: the hold buffer is invalidated by leaving S_HOLD, and the
            // bubble carries the redirect target as its address.
            pc_d      = jump_pc;
            state_d   = S_FETCH;
            order_d   = '0;
            addr_d    = jump_pc;
            running_d = 1'b0;
            intr_d    = 1'b0;
            intr_num_d = '0;
        end else if (int_take) begin
            // Injection reports the address of the next undelivered word; pc
            // and the hold buffer are untouched so that word is still delivered.
            order_d    = '0;
            addr_d     = (state_q == S_HOLD) ? hold_addr_q : pc_q;
            running_d  = 1'b0;
            intr_d     = 1'b1;
            intr_num_d = int_num;
            if (state_q == S_IDLE) begin
                state_d = S_FETCH;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                    if (!isStop) begin
                        order_d    = '0;
                        addr_d     = pc_q;
                        running_d  = 1'b0;
                        intr_d     = 1'b0;
                        intr_num_d = '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_q + 32'd4;
                        if (isStop) begin
                            hold_addr_d = pc_q;
                            hold_data_d = imem_data;
                            state_d     = S_HOLD;
                        end else begin
                            order_d    = imem_data;
                            addr_d     = pc_q;
                            running_d  = 1'b1;
                            intr_d     = 1'b0;
                            intr_num_d = '0;
                        end
                    end else if (!isStop) begin
                        order_d    = '0;
                        addr_d     = pc_q;
                        running_d  = 1'b0;
                        intr_d     = 1'b0;
                        intr_num_d = '0;
                    end
                end
                S_HOLD: begin
                    if (!isStop) begin
                        order_d    = hold_data_q;
                        addr_d     = hold_addr_q;
                        running_d  = 1'b1;
                        intr_d     = 1'b0;
                        intr_num_d = '0;
                        state_d    = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated only with non-blocking assignments so every
        // flop samples the values computed from the previous cycle.
        if (rst) begin
            // NOTE: the hold buffer is reset along with the control state; it
            // is two words, so there is no cost reason to leave it unreset.
            state_q      <= S_IDLE;
            pc_q         <= '0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            order_q      <= '0;
            addr_q       <= '0;
            running_q    <= 1'b0;
            intr_q       <= 1'b0;
            intr_num_q   <= '0;
            int_accept_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            order_q      <= order_d;
            addr_q       <= addr_d;
            running_q    <= running_d;
            intr_q       <= intr_d;
            intr_num_q   <= intr_num_d;
            int_accept_q <= int_accept_d;
        end
    end

endmodule

// File: tb/tb_order_fetch.sv
// ---------------------------------------------------------------------------
// tb_order_fetch -- scoreboard bench for order_fetch
//
// The stimulus process drives one cycle at a time, evaluates a behavioural
// model of the fetch stage (pc, a queue standing in for the hold buffer, a
// "started" flag) and pushes the expected request/accept values for that
// cycle plus the expected decode-slot contents after the edge. The monitor
// pops one entry per cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_order_fetch;

    logic        clk;
    logic        rst;
    logic        isStop;
    logic        jump;
    logic [31:0] jumpAddress;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        int_req;
    logic [7:0]  int_num;
    logic        int_accept;
    logic [31:0] order;
    logic [31:0] thisOrderAddress;
    logic        this_isRunning;
    logic        interrupt;
    logic [7:0]  interrupt_num;

    order_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .isStop           (isStop),
        .jump             (jump),
        .jumpAddress      (jumpAddress),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_data        (imem_data),
        .int_req          (int_req),
        .int_num          (int_num),
        .int_accept       (int_accept),
        .order            (order),
        .thisOrderAddress (thisOrderAddress),
        .this_isRunning   (this_isRunning),
        .interrupt        (interrupt),
        .interrupt_num    (interrupt_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] order;
        logic [31:0] addr;
        logic        running;
        logic        intr;
        logic [7:0]  num;
    } slot_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        acc;
        slot_t       next;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } word_t;

    exp_t  sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Behavioural model state.
    logic [31:0] m_pc       = '0;
    bit          m_started  = 1'b0;
    word_t       m_hold[$];
    bit          m_last_acc = 1'b0;
    slot_t       m_out      = '0;
    logic [31:0] salt       = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic slot_t mk_slot(logic [31:0] o, logic [31:0] a, logic r, logic i, logic [7:0] n);
        slot_t s;
        s.order   = o;
        s.addr    = a;
        s.running = r;
        s.intr    = i;
        s.num     = n;
        return s;
    endfunction

    // One clock cycle: drive inputs, model it, queue expectations, advance.
    task automatic step(input bit r, input bit s, input bit j, input logic [31:0] ja,
                        input bit ir, input logic [7:0] inum, input bit ack_ok,
                        output bit accepted);
        exp_t        e;
        bit          fetching;
        bit          ack;
        logic [31:0] data;
        word_t       w;

        fetching = m_started && (m_hold.size() == 0);
        e.req    = fetching && !j;
        e.addr   = m_pc;
        e.acc    = !r && !s && !j && ir && !m_last_acc;
        ack      = e.req && ack_ok;
        data     = m_pc ^ 32'hA5A5A5A5 ^ salt;

        rst         = r;
        isStop      = s;
        jump        = j;
        jumpAddress = ja;
        int_req     = ir;
        int_num     = inum;
        imem_ack    = ack;
        imem_data   = ack ? data : 32'hDEAD_BEEF;

        if (r) begin
            m_pc = '0; m_started = 0; m_hold.delete(); m_out = '0; m_last_acc = 0;
        end else if (j) begin
            m_pc = {ja[31:2], 2'b00};
            m_hold.delete();
            m_started  = 1;
            m_out      = mk_slot('0, m_pc, 0, 0, '0);
            m_last_acc = 0;
        end else if (e.acc) begin
            m_out = mk_slot('0, (m_hold.size() != 0) ? m_hold[0].addr : m_pc, 0, 1, inum);
            m_started  = 1;
            m_last_acc = 1;
        end else begin
            m_last_acc = 0;
            if (fetching && ack) begin
                if (s) begin
                    w.addr = m_pc;
                    w.data = data;
                    m_hold.push_back(w);
                end else begin
                    m_out = mk_slot(data, m_pc, 1, 0, '0);
                end
                m_pc = m_pc + 32'd4;
            end else if (m_hold.size() != 0) begin
                if (!s) begin
                    w     = m_hold.pop_front();
                    m_out = mk_slot(w.data, w.addr, 1, 0, '0);
                end
            end else if (!s) begin
                m_out = mk_slot('0, m_pc, 0, 0, '0);
            end
            m_started = 1;
        end

        e.next = m_out;
        sb_q.push_back(e);
        accepted = e.acc;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit s, input bit ack_ok);
        bit a;
        for (int i = 0; i < n; i++) step(0, s, 0, '0, 0, '0, ack_ok, a);
    endtask

    task automatic do_reset(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, '0, 1, a);
    endtask

    // Monitor: per-cycle request/accept now, slot contents from previous entry.
    initial begin
        exp_t e;
        exp_t prev;
        bit   have_prev;
        slot_t act;
        have_prev = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e   = sb_q.pop_front();
                act = {order, thisOrderAddress, this_isRunning, interrupt, interrupt_num};
                check("imem_req", {127'd0, imem_req}, {127'd0, e.req});
                if (e.req) check("imem_addr", {96'd0, imem_addr}, {96'd0, e.addr});
                check("int_accept", {127'd0, int_accept}, {127'd0, e.acc});
                if (have_prev) check("slot", {54'd0, act}, {54'd0, prev.next});
                prev      = e;
                have_prev = 1;
            end
        end
    end

    initial begin
        bit          a;
        bit          pend;
        logic [7:0]  pnum;

        rst = 1; isStop = 0; jump = 0; jumpAddress = '0;
        imem_ack = 0; imem_data = '0; int_req = 0; int_num = '0;
        @(posedge clk);
        #1;

        // Reset, then memory answers every request: 0, 4, 8, 12 back to back.
        do_reset(2);
        run(8, 0, 1);

        // Stall lands on the ack for address 8 and lasts three cycles.
        do_reset(1);
        run(3, 0, 1);
        run(3, 1, 1);
        run(3, 0, 1);

        // Redirect to 0x1003 while a held word waits.
        run(1, 1, 1);
        step(0, 1, 1, 32'h0000_1003, 0, '0, 1, a);
        run(4, 0, 1);

        // Interrupt with pc=0x40, ack arriving the same cycle; request held
        // for several cycles to see the gap between pulses.
        step(0, 0, 1, 32'h0000_0040, 0, '0, 1, a);
        step(0, 0, 0, '0, 1, 8'h21, 1, a);
        step(0, 0, 0, '0, 1, 8'h21, 1, a);
        step(0, 0, 0, '0, 1, 8'h21, 1, a);
        run(3, 0, 1);

        // Interrupt while a word is held, then stall released.
        run(1, 1, 1);
        step(0, 0, 0, '0, 1, 8'h7E, 1, a);
        run(3, 0, 1);

        // Wrap of pc at the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFC, 0, '0, 1, a);
        run(4, 0, 1);

        // Reset while a request is outstanding and acked that same cycle.
        step(1, 0, 0, '0, 0, '0, 1, a);
        run(4, 0, 1);

        // Randomized traffic.
        pend = 0;
        pnum = '0;
        for (int i = 0; i < 2000; i++) begin
            bit          r, s, j;
            logic [31:0] ja;
            salt = $urandom;
            r  = ($urandom_range(0, 99) == 0);
            j  = ($urandom_range(0, 99) < 5);
            s  = ($urandom_range(0, 99) < 30);
            ja = $urandom;
            if (!pend && ($urandom_range(0, 99) < 4)) begin
                pend = 1;
                pnum = 8'($urandom);
            end
            step(r, s, j, ja, pend, pnum, ($urandom_range(0, 99) < 70), a);
            if (a) pend = 0;
        end

        do_reset(2);
        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) check("drain", 128'(sb_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
